// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in serial-out serializer.
package piso_pkg;

    // Controller states: IDLE waits for a held word, SHIFT streams bits out.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int PISO_DEFAULT_WIDTH = 4;

endpackage

// File: rtl/bit_counter.sv
// Mod-WIDTH bit counter with synchronous clear, count enable and terminal-count flag.
module bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = PISO_DEFAULT_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     enable,
    output logic [$clog2(WIDTH)-1:0] cnt,
    output logic                     terminal
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear wins over enable so a freshly loaded word always starts at bit 0.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Counter register, forced to zero by the asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt      = cnt_q;
    assign terminal = (cnt_q == CNT_LAST);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer: one holding register in front of a
// shift register, so the next word can wait while the current one streams.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = PISO_DEFAULT_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pin,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] hold_q;
    logic [WIDTH-1:0] hold_d;
    logic             hold_full_q;
    logic             hold_full_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    logic             accept;
    logic             load_shreg;
    logic             cnt_enable;
    logic             terminal;
    logic [CNT_W-1:0] cnt;
    logic             out_bit;

    // No bypass: a word is only taken while the holding register is empty.
    assign load_ready = !hold_full_q;
    assign accept     = load_valid && !hold_full_q;
    assign cnt_enable = (state_q == SHIFT);

    bit_counter #(
        .WIDTH(WIDTH)
    ) u_bit_counter (
        .clk     (clk),
        .reset   (reset),
        .clear   (load_shreg),
        .enable  (cnt_enable),
        .cnt     (cnt),
        .terminal(terminal)
    );

    // Next-state logic: move held words into the shifter and shift one bit per cycle.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shreg_d     = shreg_q;
        load_shreg  = 1'b0;

        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    shreg_d     = hold_q;
                    hold_full_d = 1'b0;
                    load_shreg  = 1'b1;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                if (MSB_FIRST != 0) begin
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                end else begin
                    shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
                end
                if (terminal) begin
                    if (hold_full_q) begin
                        shreg_d     = hold_q;
                        hold_full_d = 1'b0;
                        load_shreg  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
        endcase

        // Accept only happens when hold is empty, so it never collides with a drain.
        if (accept) begin
            hold_d      = pin;
            hold_full_d = 1'b1;
        end
    end

    // Controller and datapath registers, all cleared immediately by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shreg_q     <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shreg_q     <= shreg_d;
        end
    end

    assign out_bit    = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];
    assign sout_valid = (state_q == SHIFT);
    assign sout       = (state_q == SHIFT) && out_bit;
    assign done       = (state_q == SHIFT) && (cnt == CNT_LAST);

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: one MSB-first and one LSB-first instance.
module tb_piso_serializer;

    localparam int W = 4;

    typedef struct packed {
        logic b;
        logic d;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] pin_m;
    logic [W-1:0] pin_l;
    logic         lv_m;
    logic         lv_l;
    logic         rdy_m;
    logic         rdy_l;
    logic         sout_m;
    logic         sout_l;
    logic         sv_m;
    logic         sv_l;
    logic         done_m;
    logic         done_l;

    exp_t q_m[$];
    exp_t q_l[$];
    exp_t e_m;
    exp_t e_l;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   stall_m = 0;
    int   stall_l = 0;
    logic prev_m = 1'b0;
    logic prev_l = 1'b0;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
        .clk(clk), .reset(reset), .pin(pin_m), .load_valid(lv_m),
        .load_ready(rdy_m), .sout(sout_m), .sout_valid(sv_m), .done(done_m)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
        .clk(clk), .reset(reset), .pin(pin_l), .load_valid(lv_l),
        .load_ready(rdy_l), .sout(sout_l), .sout_valid(sv_l), .done(done_l)
    );

    always #5 clk = ~clk;

    // Expected bit stream for one accepted word, in emission order.
    task automatic push_word(input bit lsb_dut, input logic [W-1:0] word);
        exp_t e;
        for (int i = 0; i < W; i++) begin
            e.b = lsb_dut ? word[i] : word[W-1-i];
            e.d = (i == W - 1);
            if (lsb_dut) q_l.push_back(e);
            else         q_m.push_back(e);
        end
    endtask

    // MSB-first monitor: pops one expected bit per valid cycle, polices gaps and latency.
    always @(posedge clk) begin
        #1;
        if (reset) begin
            stall_m = 0;
            prev_m  = 1'b0;
        end else begin
            if (sv_m) begin
                n_cmp++;
                if (q_m.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL msb_unexpected_bit: sout_valid=%b required 0", sv_m);
                end else begin
                    e_m = q_m.pop_front();
                    n_cmp++;
                    if (sout_m !== e_m.b) begin
                        n_fail++;
                        $display("[TB] FAIL msb_sout: got %b required %b", sout_m, e_m.b);
                    end
                    n_cmp++;
                    if (done_m !== e_m.d) begin
                        n_fail++;
                        $display("[TB] FAIL msb_done: got %b required %b", done_m, e_m.d);
                    end
                end
                stall_m = 0;
            end else begin
                n_cmp++;
                if (done_m !== 1'b0 || sout_m !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL msb_idle_out: sout=%b done=%b required 0 0", sout_m, done_m);
                end
                if (q_m.size() != 0) begin
                    stall_m++;
                    n_cmp++;
                    if (prev_m || stall_m > 1) begin
                        n_fail++;
                        $display("[TB] FAIL msb_gap: sout_valid=0 with %0d bits pending, stall=%0d required valid",
                                 q_m.size(), stall_m);
                    end
                end
            end
            prev_m = sv_m;
        end
    end

    // LSB-first monitor: same policing for the second instance.
    always @(posedge clk) begin
        #1;
        if (reset) begin
            stall_l = 0;
            prev_l  = 1'b0;
        end else begin
            if (sv_l) begin
                n_cmp++;
                if (q_l.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL lsb_unexpected_bit: sout_valid=%b required 0", sv_l);
                end else begin
                    e_l = q_l.pop_front();
                    n_cmp++;
                    if (sout_l !== e_l.b) begin
                        n_fail++;
                        $display("[TB] FAIL lsb_sout: got %b required %b", sout_l, e_l.b);
                    end
                    n_cmp++;
                    if (done_l !== e_l.d) begin
                        n_fail++;
                        $display("[TB] FAIL lsb_done: got %b required %b", done_l, e_l.d);
                    end
                end
                stall_l = 0;
            end else begin
                n_cmp++;
                if (done_l !== 1'b0 || sout_l !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL lsb_idle_out: sout=%b done=%b required 0 0", sout_l, done_l);
                end
                if (q_l.size() != 0) begin
                    stall_l++;
                    n_cmp++;
                    if (prev_l || stall_l > 1) begin
                        n_fail++;
                        $display("[TB] FAIL lsb_gap: sout_valid=0 with %0d bits pending, stall=%0d required valid",
                                 q_l.size(), stall_l);
                    end
                end
            end
            prev_l = sv_l;
        end
    end

    // Reset held with a word offered: nothing accepted, outputs quiet, nothing after release.
    task automatic test_reset();
        reset = 1'b1;
        pin_m = 4'b0101;
        lv_m  = 1'b1;
        pin_l = 4'b0101;
        lv_l  = 1'b1;
        repeat (2) begin
            @(negedge clk);
            n_cmp++;
            if (rdy_m !== 1'b1 || sv_m !== 1'b0 || done_m !== 1'b0 || sout_m !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL reset_outputs_msb: rdy=%b sv=%b done=%b sout=%b required 1 0 0 0",
                         rdy_m, sv_m, done_m, sout_m);
            end
            n_cmp++;
            if (rdy_l !== 1'b1 || sv_l !== 1'b0 || done_l !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL reset_outputs_lsb: rdy=%b sv=%b done=%b required 1 0 0",
                         rdy_l, sv_l, done_l);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        lv_m  = 1'b0;
        lv_l  = 1'b0;
        repeat (6) @(negedge clk);
        n_cmp++;
        if (rdy_m !== 1'b1 || sv_m !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_release: rdy=%b sv=%b required 1 0", rdy_m, sv_m);
        end
    endtask

    // One MSB-first word: four bits, done on the last, then back to idle.
    task automatic test_single();
        @(negedge clk);
        n_cmp++;
        if (rdy_m !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL single_ready: got %b required 1", rdy_m);
        end
        pin_m = 4'b1101;
        lv_m  = 1'b1;
        push_word(1'b0, 4'b1101);
        @(negedge clk);
        lv_m = 1'b0;
        n_cmp++;
        if (rdy_m !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL single_busy: load_ready=%b required 0", rdy_m);
        end
        repeat (7) @(negedge clk);
        n_cmp++;
        if (q_m.size() != 0 || sv_m !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL single_drain: pending=%0d sv=%b required 0 0", q_m.size(), sv_m);
        end
    endtask

    // Two words offered as early as possible: contiguous eight-bit stream.
    task automatic test_back_to_back();
        logic [W-1:0] pins[3] = '{4'b0101, 4'b0110, 4'b0110};
        logic         rdy [3] = '{1'b1, 1'b0, 1'b1};
        logic         push[3] = '{1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (rdy_m !== rdy[k]) begin
                n_fail++;
                $display("[TB] FAIL b2b_ready[%0d]: got %b required %b", k, rdy_m, rdy[k]);
            end
            pin_m = pins[k];
            lv_m  = 1'b1;
            if (push[k]) push_word(1'b0, pins[k]);
        end
        @(negedge clk);
        lv_m = 1'b0;
        n_cmp++;
        if (rdy_m !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL b2b_hold_full: load_ready=%b required 0", rdy_m);
        end
        repeat (10) @(negedge clk);
        n_cmp++;
        if (q_m.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL b2b_drain: pending=%0d required 0", q_m.size());
        end
    endtask

    // LSB-first instance emits bit 0 first.
    task automatic test_lsb_first();
        @(negedge clk);
        n_cmp++;
        if (rdy_l !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL lsb_ready: got %b required 1", rdy_l);
        end
        pin_l = 4'b0111;
        lv_l  = 1'b1;
        push_word(1'b1, 4'b0111);
        @(negedge clk);
        lv_l = 1'b0;
        repeat (7) @(negedge clk);
        n_cmp++;
        if (q_l.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL lsb_drain: pending=%0d required 0", q_l.size());
        end
    endtask

    // Asynchronous reset two bits into a word: outputs drop at once, no leftovers.
    task automatic test_async_reset();
        @(negedge clk);
        pin_m = 4'b1111;
        lv_m  = 1'b1;
        push_word(1'b0, 4'b1111);
        @(negedge clk);
        lv_m = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b1;
        pin_m = 4'b1010;
        lv_m  = 1'b1;
        #1;
        n_cmp++;
        if (sv_m !== 1'b0 || sout_m !== 1'b0 || done_m !== 1'b0 || rdy_m !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL async_reset_outputs: sv=%b sout=%b done=%b rdy=%b required 0 0 0 1",
                     sv_m, sout_m, done_m, rdy_m);
        end
        n_cmp++;
        if (q_m.size() != 2) begin
            n_fail++;
            $display("[TB] FAIL async_reset_bits_before: pending=%0d required 2", q_m.size());
        end
        q_m.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        lv_m  = 1'b0;
        n_cmp++;
        if (rdy_m !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL async_reset_ready: got %b required 1", rdy_m);
        end
        repeat (8) @(negedge clk);
        n_cmp++;
        if (sv_m !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL async_reset_residue: sv=%b required 0", sv_m);
        end
    endtask

    // load_valid held high while pin changes: only words seen with load_ready=1 go out.
    task automatic test_ignore_while_busy();
        logic [W-1:0] pins[7] = '{4'b1001, 4'b0100, 4'b1010, 4'b0100, 4'b0000, 4'b0111, 4'b1100};
        logic         rdy [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            n_cmp++;
            if (rdy_m !== rdy[k]) begin
                n_fail++;
                $display("[TB] FAIL busy_ready[%0d]: got %b required %b", k, rdy_m, rdy[k]);
            end
            pin_m = pins[k];
            lv_m  = 1'b1;
            if (rdy[k]) push_word(1'b0, pins[k]);
        end
        @(negedge clk);
        lv_m = 1'b0;
        repeat (14) @(negedge clk);
        n_cmp++;
        if (q_m.size() != 0 || sv_m !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL busy_drain: pending=%0d sv=%b required 0 0", q_m.size(), sv_m);
        end
    endtask

    initial begin
        reset = 1'b1;
        pin_m = '0;
        pin_l = '0;
        lv_m  = 1'b0;
        lv_l  = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_lsb_first();
        test_async_reset();
        test_ignore_while_busy();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001: Parameter WIDTH, default 4, parallel word width in bits (WIDTH >= 2).
REQ-002: Parameter MSB_FIRST, default 1; 1 = emit bit WIDTH-1 first, 0 = emit bit 0 first.
REQ-003: clk  input  1  rising-edge clock; the block has one clock.
REQ-004: reset  input  1  asynchronous, active-high reset.
REQ-005: pin  input  WIDTH  parallel word from the upstream PIPO register stage.
REQ-006: load_valid  input  1  pin holds a word to be accepted.
REQ-007: load_ready  output  1  holding register is empty and can accept a word.
REQ-008: sout  output  1  serial data bit.
REQ-009: sout_valid  output  1  sout carries a valid data bit this cycle.
REQ-010: done  output  1  one-cycle pulse while the last bit of a word is on sout.

Function
REQ-011: Datapath: one WIDTH-bit holding register (hold, flag hold_full), one WIDTH-bit shift register (shreg), one bit counter (cnt) of width $clog2(WIDTH).
REQ-012: load_ready SHALL equal !hold_full (combinational); there is no bypass, so a word is never accepted on an edge where hold_full=1, even if hold drains on that edge.
REQ-013: Accept: at a rising edge with load_valid=1 and load_ready=1, the block captures pin into hold and sets hold_full=1; pin is ignored at every other edge.
REQ-014: FSM states: IDLE, SHIFT.
REQ-015: IDLE with hold_full=1: at the next edge, hold goes to shreg, cnt=0, hold_full=0, state=SHIFT; IDLE with hold_full=0 stays IDLE.
REQ-016: Latency: a word accepted at edge N in IDLE has its first bit on sout, with sout_valid=1, from edge N+1 to N+2.
REQ-017: In SHIFT, sout = shreg[WIDTH-1] (MSB_FIRST=1) or shreg[0] (MSB_FIRST=0), and sout_valid=1; each edge shifts shreg one position toward the output bit and increments cnt.
REQ-018: done=1 only when in SHIFT with cnt==WIDTH-1.
REQ-019: At the edge ending the cnt==WIDTH-1 cycle: if hold_full=1, load hold into shreg, cnt=0, clear hold_full and stay in SHIFT, giving zero gap between words; otherwise go to IDLE.
REQ-020: In IDLE, sout=0, sout_valid=0, done=0.
REQ-021: A word is always emitted completely, exactly WIDTH bits, in order; words are emitted in acceptance order, none is dropped or duplicated.
REQ-022: Sustained throughput SHALL be one bit per clock with continuous sout_valid while upstream keeps hold filled.

Reset
REQ-023: Asserting reset SHALL immediately, without waiting for a clock edge, set state=IDLE, hold_full=0, shreg=0, hold=0 and cnt=0.
REQ-024: During reset, outputs SHALL be load_ready=1, sout=0, sout_valid=0 and done=0; no word is accepted while reset=1.
REQ-025: Reset mid-word SHALL discard the partial word and any held word; no residual bits appear after release.

Structure
REQ-026: Shared package piso_pkg SHALL hold the state enum (IDLE, SHIFT) and the constant PISO_DEFAULT_WIDTH=4.
REQ-027: One sub-module, bit_counter, SHALL implement a mod-WIDTH counter with clear, enable and a terminal-count output; it drives cnt and done.

Verification (WIDTH=4 unless stated)
REQ-028: Hold reset=1 with pin=4'b0101 and load_valid=1 for 2 cycles -> load_ready=1, sout_valid=0, done=0; after release, no bits are emitted.
REQ-029: Accept 4'b1101 once, MSB_FIRST=1 -> sout=1,1,0,1 on 4 consecutive cycles, done high on the 4th only, then IDLE.
REQ-030: Accept 4'b0101 then 4'b0110 as early as load_ready allows -> 8 contiguous valid bits 0,1,0,1,0,1,1,0; done pulses on bits 4 and 8; load_ready=0 while hold is full.
REQ-031: MSB_FIRST=0, accept 4'b0111 -> sout=1,1,1,0.
REQ-032: Assert reset asynchronously after 2 bits of 4'b1111 -> sout and sout_valid drop before the next edge; after release, load_ready=1 and no leftover bits appear.
REQ-033: Hold load_valid=1 while cycling pin through 4'b0100, 4'b0000 and 4'b0111 during load_ready=0 -> only the words present on edges with load_ready=1 are serialized.
